// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA pixel-timing generator. A prescaler divides the board
//               clock down to the pixel rate, and horizontal/vertical
//               counters step on each pixel tick. Sync, active-video and
//               line/frame start pulses are decoded from the counter values
//               being loaded, so every output is a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    // ------------------------------------------------------------------------
    // Derived timing constants. Boundary comparisons use 11 bits so that a
    // 1024-wide total (or a sync region ending at 1024) does not truncate.
    // ------------------------------------------------------------------------
    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last     = 10'(c_v_total - 1);
    localparam logic [10:0] c_h_act_end  = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_act_end  = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic       r_pix_tick;
    logic       r_line_start;
    logic       r_frame_start;

    // Pixel advance strobe: true on the clk where the prescaler wraps.
    logic       w_adv;

    // Next counter values and their decodes
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_x_wrap;
    logic       w_hsync_nxt;
    logic       w_vsync_nxt;
    logic       w_active_nxt;

    // ------------------------------------------------------------------------
    // Prescaler. With CLK_DIV == 1 every enabled clk is a pixel, so no
    // counter is built at all.
    // ------------------------------------------------------------------------
    generate
        if (CLK_DIV > 1) begin : g_presc_divn
            localparam int               c_pw         = $clog2(CLK_DIV);
            localparam logic [c_pw-1:0]  c_presc_last = c_pw'(CLK_DIV - 1);

            logic [c_pw-1:0] r_presc;

            // Count 0..CLK_DIV-1 while enabled; hold its value when en is low
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_presc <= '0;
                end else if (en) begin
                    if (r_presc == c_presc_last) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + c_pw'(1);
                    end
                end
            end

            assign w_adv = en && (r_presc == c_presc_last);
        end else begin : g_presc_div1
            assign w_adv = en;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-position computation and decode of that position. Decoding the
    // value about to be loaded gives zero latency between counters and syncs.
    // ------------------------------------------------------------------------
    // Compute the pixel position that the next advance will land on
    always_comb begin
        w_x_wrap = (r_x == c_h_last);
        w_x_nxt  = w_x_wrap ? 10'd0 : (r_x + 10'd1);
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = (r_y == c_v_last) ? 10'd0 : (r_y + 10'd1);
        end
    end

    // Decode sync and active-video levels for the upcoming position
    always_comb begin
        w_hsync_nxt  = ~HSYNC_POL;
        w_vsync_nxt  = ~VSYNC_POL;
        w_active_nxt = 1'b0;

        if (({1'b0, w_x_nxt} >= c_hs_start) && ({1'b0, w_x_nxt} < c_hs_end)) begin
            w_hsync_nxt = HSYNC_POL;
        end
        if (({1'b0, w_y_nxt} >= c_vs_start) && ({1'b0, w_y_nxt} < c_vs_end)) begin
            w_vsync_nxt = VSYNC_POL;
        end
        if (({1'b0, w_x_nxt} < c_h_act_end) && ({1'b0, w_y_nxt} < c_v_act_end)) begin
            w_active_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, decoded levels and strobes. The reset position is the last
    // pixel of the last line so the first advance lands on (0,0) and raises
    // both start pulses. Strobes drop on every clk that is not an advance,
    // including the whole of any en-low interval.
    // ------------------------------------------------------------------------
    // Step counters and register decodes/pulses on each pixel advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= c_h_last;
            r_y           <= c_v_last;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b0;
            r_pix_tick    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_adv) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_active      <= w_active_nxt;
            r_pix_tick    <= 1'b1;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap && (r_y == c_v_last);
        end else begin
            r_pix_tick    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign pix_tick    = r_pix_tick;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen using a small
//               8/2/3/3 x 4/1/2/1 timing (16 x 8 totals), one instance with
//               CLK_DIV=1 and one with CLK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       pix_tick, hsync, vsync, active, line_start, frame_start;
    logic [9:0] x, y;

    logic       rst4_n = 1'b0;
    logic       en4 = 1'b1;
    logic       pix_tick4, hsync4, vsync4, active4, line_start4, frame_start4;
    logic [9:0] x4, y4;

    int checks = 0;
    int errors = 0;

    // Reference position for the CLK_DIV=1 instance
    int ex = 15;
    int ey = 7;
    // Reference position and prescaler for the CLK_DIV=4 instance
    int mx4 = 15;
    int my4 = 7;
    int pc4 = 0;

    int hs_low, vs_low, ls_cnt, fs_cnt, tick_cnt;
    logic exp_tick4;

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .active(active),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(4)
    ) dut4 (
        .clk(clk), .rst_n(rst4_n), .en(en4),
        .pix_tick(pix_tick4), .hsync(hsync4), .vsync(vsync4), .active(active4),
        .x(x4), .y(y4), .line_start(line_start4), .frame_start(frame_start4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_model();
        if (ex == 15) begin
            ex = 0;
            ey = (ey == 7) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    // Compare every output of the CLK_DIV=1 instance with the reference
    task automatic check_main(input logic ticked);
        check("x", 32'(x), ex);
        check("y", 32'(y), ey);
        check("hsync", 32'(hsync), (ex >= 10 && ex <= 12) ? 0 : 1);
        check("vsync", 32'(vsync), (ey >= 5 && ey <= 6) ? 0 : 1);
        check("active", 32'(active), (ex < 8 && ey < 4) ? 1 : 0);
        check("pix_tick", 32'(pix_tick), 32'(ticked));
        check("line_start", 32'(line_start), (ticked && ex == 0) ? 1 : 0);
        check("frame_start", 32'(frame_start), (ticked && ex == 0 && ey == 0) ? 1 : 0);
    endtask

    initial begin
        // ---- Reset state ----
        step();
        step();
        check("rst_x", 32'(x), 15);
        check("rst_y", 32'(y), 7);
        check("rst_active", 32'(active), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_pix_tick", 32'(pix_tick), 0);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_frame_start", 32'(frame_start), 0);

        // ---- Release reset: first edge lands on (0,0) with both pulses ----
        rst_n = 1'b1;
        step();
        adv_model();
        check_main(1'b1);
        check("first_frame_start", 32'(frame_start), 1);

        // ---- Free run two full frames ----
        hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            adv_model();
            check_main(1'b1);
            if (hsync == 1'b0) hs_low++;
            if (vsync == 1'b0) vs_low++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
        end
        check("hsync_low_count", hs_low, 48);
        check("vsync_low_count", vs_low, 64);
        check("line_start_count", ls_cnt, 16);
        check("frame_start_count", fs_cnt, 2);

        // ---- Move to (5,2) then freeze with en low ----
        for (int i = 0; i < 37; i++) begin
            step();
            adv_model();
            check_main(1'b1);
        end
        check("pre_freeze_x", 32'(x), 5);
        check("pre_freeze_y", 32'(y), 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_main(1'b0);
        end
        en = 1'b1;
        step();
        adv_model();
        check_main(1'b1);
        check("resume_x", 32'(x), 6);

        // ---- Move to (11,5) then assert reset between edges ----
        for (int i = 0; i < 53; i++) begin
            step();
            adv_model();
            check_main(1'b1);
        end
        check("pre_reset_x", 32'(x), 11);
        check("pre_reset_y", 32'(y), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", 32'(x), 15);
        check("async_rst_y", 32'(y), 7);
        check("async_rst_active", 32'(active), 0);
        check("async_rst_hsync", 32'(hsync), 1);
        check("async_rst_vsync", 32'(vsync), 1);
        ex = 15;
        ey = 7;
        step();
        step();
        check_main(1'b0);
        rst_n = 1'b1;
        step();
        adv_model();
        check_main(1'b1);
        check("post_rst_frame_start", 32'(frame_start), 1);
        step();
        adv_model();
        check_main(1'b1);

        // ---- CLK_DIV=4 instance ----
        check("div4_rst_x", 32'(x4), 15);
        check("div4_rst_pix_tick", 32'(pix_tick4), 0);
        rst4_n = 1'b1;
        tick_cnt = 0;
        ls_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (pc4 == 3) begin
                pc4 = 0;
                exp_tick4 = 1'b1;
                if (mx4 == 15) begin
                    mx4 = 0;
                    my4 = (my4 == 7) ? 0 : my4 + 1;
                end else begin
                    mx4 = mx4 + 1;
                end
            end else begin
                pc4 = pc4 + 1;
                exp_tick4 = 1'b0;
            end
            check("div4_pix_tick", 32'(pix_tick4), 32'(exp_tick4));
            check("div4_x", 32'(x4), mx4);
            check("div4_y", 32'(y4), my4);
            check("div4_line_start", 32'(line_start4), (exp_tick4 && mx4 == 0) ? 1 : 0);
            check("div4_frame_start", 32'(frame_start4), (exp_tick4 && mx4 == 0 && my4 == 0) ? 1 : 0);
            if (pix_tick4) tick_cnt++;
            if (line_start4) ls_cnt++;
        end
        check("div4_tick_count", tick_cnt, 40);
        check("div4_line_start_count", ls_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing generator for the VGA test top level.
- Produces the horizontal and vertical sync, active-video and pixel coordinates that drive the VGA output pins (PIN_20..PIN_24) through the colour/pattern logic.
- Runs off the 16 MHz board clock, with an optional integer prescaler to derive the pixel rate.
- All outputs are registered, so the pins see glitch-free sync.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
CLK_DIV, 1, clk cycles per pixel (>=1)

Ports:
clk  input  1  system clock (16 MHz)
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; low freezes timing
pix_tick  output  1  one-clk strobe, pixel advance
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
active  output  1  high while x<H_ACTIVE and y<V_ACTIVE
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
line_start  output  1  one-clk pulse when x becomes 0
frame_start  output  1  one-clk pulse when x and y both become 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be <=1024 (10-bit counters).
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low; rst_n and clk are the only reset and clock.
  - While rst_n is low, regardless of clk:
    - prescaler=0, x=H_TOTAL-1, y=V_TOTAL-1
    - active=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL
    - pix_tick=0, line_start=0, frame_start=0
- Prescaler:
  - Counts 0..CLK_DIV-1 on each clk while en=1 and wraps to 0.
  - pix_tick is registered high for exactly one clk each time the prescaler wraps.
  - With CLK_DIV=1, pix_tick=1 on every enabled clk.
- Counters advance on the same edge that asserts pix_tick:
  - x <= (x==H_TOTAL-1) ? 0 : x+1.
  - y changes only when x wraps: y <= (y==V_TOTAL-1) ? 0 : y+1.
  - Because of the reset position, the first pixel advance after reset lands on (0,0).
- Decode (registered, same edge as the counters, from the new x/y values):
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
  - active as defined in Ports.
  - Latency from counter update to decoded outputs: 0 clk.
- Pulse outputs:
  - line_start=1 for exactly one clk on the edge where x becomes 0.
  - frame_start=1 for exactly one clk on the edge where x and y both become 0.
  - Both are 0 on every other clk, including the remaining CLK_DIV-1 clks of that pixel.
- en=0:
  - Prescaler, x, y, hsync, vsync and active hold.
  - pix_tick, line_start and frame_start are forced 0.
  - When en returns high, the prescaler resumes from its held value. No pixel is skipped or repeated.
- Simultaneous x and y wrap produces both line_start and frame_start on the same clk.
- rst_n asserted mid-frame: outputs take reset values immediately (asynchronously). After rst_n deasserts, the next frame starts cleanly at (0,0).

Test Plan:
All scenarios use H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), CLK_DIV=1, sync polarity 0, unless stated.
1. Release rst_n with en=1 -> after first edge: x=0, y=0, active=1, line_start=1, frame_start=1 for exactly one clk; hsync=vsync=1.
2. Free run 64 clks -> hsync=0 exactly at x=10,11,12 (3 clks) every 16 clks; active=0 for x>=8; line_start period 16.
3. Free run 256 clks -> vsync=0 for exactly y=5,6 (32 clks); frame_start every 128 clks; active never 1 for y>=4.
4. CLK_DIV=4 -> pix_tick every 4th clk; x advances once per 4 clks; line_start/frame_start stay 1 clk wide.
5. Drop en at x=5, y=2 for 10 clks -> x, y, hsync, vsync and active frozen; pulses 0; the first pixel advance after en rises gives x=6.
6. Assert rst_n at x=11, y=5 between clk edges -> outputs go to reset values at once, without a clk edge (x=15, y=7, active=0, syncs 1); after release, frame_start fires on the first edge.
